// File: rtl/instr_encoder.sv
// instr_encoder: RV32 instruction encoder with LI pseudo-instruction expansion
// into one or two words, valid/ready on both sides.
module instr_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_kind,
    input  logic [2:0]  req_funct3,
    input  logic [6:0]  req_funct7,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last,
    output logic        err,
    output logic [15:0] instr_count
);
    typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;
    state_t state, state_nx;
    logic [31:0] w1, w2, word2;
    logic [19:0] hi;
    logic [11:0] lo;
    logic two, bad, pend, accept, hs, fit12, fit13, fit21, is_shift;
    assign fit12 = &req_imm[31:11] | ~|req_imm[31:11];
    assign fit13 = &req_imm[31:12] | ~|req_imm[31:12];
    assign fit21 = &req_imm[31:20] | ~|req_imm[31:20];
    assign is_shift = req_funct3[1:0] == 2'b01;
    assign lo = req_imm[11:0];
    // upper part rounds up when the sign-extended low part is negative
    assign hi = req_imm[31:12] + {19'd0, req_imm[11]};
    assign req_ready = state == IDLE;
    assign out_valid = state != IDLE;
    assign accept = req_valid & req_ready;
    assign hs = out_valid & out_ready;
    always_comb begin
        w1 = 32'd0;
        w2 = {lo, req_rd, 3'b000, req_rd, 7'b0010011};
        two = 1'b0;
        bad = 1'b0;
        case (req_kind)
            4'd0: w1 = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, 7'b0110011};
            4'd1: begin
                w1 = is_shift ? {req_funct7, req_imm[4:0], req_rs1, req_funct3, req_rd, 7'b0010011}
                              : {req_imm[11:0], req_rs1, req_funct3, req_rd, 7'b0010011};
                bad = is_shift ? |req_imm[31:5] : !fit12;
            end
            4'd2: begin
                w1 = {req_imm[11:0], req_rs1, req_funct3, req_rd, 7'b0000011};
                bad = !fit12;
            end
            4'd3: begin
                w1 = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], 7'b0100011};
                bad = !fit12;
            end
            4'd4: begin
                w1 = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                      req_imm[4:1], req_imm[11], 7'b1100011};
                bad = !fit13 | req_imm[0];
            end
            4'd5: begin
                w1 = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, 7'b1101111};
                bad = !fit21 | req_imm[0];
            end
            4'd6: begin
                w1 = {req_imm[11:0], req_rs1, 3'b000, req_rd, 7'b1100111};
                bad = !fit12;
            end
            4'd7: w1 = {req_imm[31:12], req_rd, 7'b0110111};
            4'd8: w1 = {req_imm[31:12], req_rd, 7'b0010111};
            4'd9: begin
                w1 = fit12 ? {lo, 5'd0, 3'b000, req_rd, 7'b0010011} : {hi, req_rd, 7'b0110111};
                two = !fit12 & |lo;
            end
            default: bad = 1'b1;
        endcase
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (req_valid && !bad) ? EMIT1 : IDLE;
            EMIT1:   state_nx = !out_ready ? EMIT1 : pend ? EMIT2 : IDLE;
            EMIT2:   state_nx = out_ready ? IDLE : EMIT2;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            out_instr   <= 32'd0;
            out_last    <= 1'b0;
            word2       <= 32'd0;
            pend        <= 1'b0;
            err         <= 1'b0;
            instr_count <= 16'd0;
        end else begin
            err <= accept & bad;
            if (hs) instr_count <= instr_count + 16'd1;
            if (accept && !bad) begin
                out_instr <= w1;
                out_last  <= !two;
                word2     <= w2;
                pend      <= two;
            end else if (hs && state == EMIT1 && pend) begin
                out_instr <= word2;
                out_last  <= 1'b1;
                pend      <= 1'b0;
            end
        end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: table vectors, randomized requests against a reference model,
// and hand sequences for backpressure and mid-expansion reset.
module tb_instr_encoder;
    logic        clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, out_ready = 1'b0;
    logic [3:0]  req_kind = '0;
    logic [2:0]  req_funct3 = '0;
    logic [6:0]  req_funct7 = '0;
    logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
    logic [31:0] req_imm = '0;
    logic        req_ready, out_valid, out_last, err;
    logic [31:0] out_instr;
    logic [15:0] instr_count;
    int checks = 0, errors = 0, exp_count = 0;

    instr_encoder dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_funct3(req_funct3), .req_funct7(req_funct7),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_last(out_last), .err(err), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  kind;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        int          n;
        logic [31:0] w0, w1;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] itype(input logic [31:0] op, input logic [31:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [31:0] imm);
        return ((imm & 32'hfff) << 20) | (32'(rs1) << 15) | (f3 << 12) | (32'(rd) << 7) | op;
    endfunction

    function automatic void model(input vec_t v, output int n, output logic [31:0] e0,
                                  output logic [31:0] e1);
        int s, lo;
        logic [31:0] imm, f, rr;
        bit in12;
        imm = v.imm;
        s = v.imm;
        f = 32'(v.f3) << 12;
        rr = (32'(v.rs2) << 20) | (32'(v.rs1) << 15);
        in12 = s >= -2048 && s <= 2047;
        n = 1;
        e0 = 0;
        e1 = 0;
        case (v.kind)
            0: e0 = (32'(v.f7) << 25) | rr | f | (32'(v.rd) << 7) | 32'h33;
            1: if (v.f3 == 1 || v.f3 == 5) begin
                   n = imm <= 31 ? 1 : 0;
                   e0 = (32'(v.f7) << 25) | (imm << 20) | (32'(v.rs1) << 15) | f | (32'(v.rd) << 7) | 32'h13;
               end else begin
                   n = in12 ? 1 : 0;
                   e0 = itype(32'h13, 32'(v.f3), v.rd, v.rs1, imm);
               end
            2: begin n = in12 ? 1 : 0; e0 = itype(32'h03, 32'(v.f3), v.rd, v.rs1, imm); end
            3: begin
                n = in12 ? 1 : 0;
                e0 = (((imm >> 5) & 32'h7f) << 25) | rr | f | ((imm & 32'h1f) << 7) | 32'h23;
            end
            4: begin
                n = (s >= -4096 && s <= 4095 && s % 2 == 0) ? 1 : 0;
                e0 = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3f) << 25) | rr | f
                   | (((imm >> 1) & 32'hf) << 8) | (((imm >> 11) & 1) << 7) | 32'h63;
            end
            5: begin
                n = (s >= -1048576 && s <= 1048575 && s % 2 == 0) ? 1 : 0;
                e0 = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3ff) << 21)
                   | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hff) << 12)
                   | (32'(v.rd) << 7) | 32'h6f;
            end
            6: begin n = in12 ? 1 : 0; e0 = itype(32'h67, 0, v.rd, v.rs1, imm); end
            7: e0 = (imm & 32'hfffff000) | (32'(v.rd) << 7) | 32'h37;
            8: e0 = (imm & 32'hfffff000) | (32'(v.rd) << 7) | 32'h17;
            9: if (in12) e0 = itype(32'h13, 0, v.rd, 5'd0, imm);
               else begin
                   lo = int'(imm & 32'hfff);
                   if (lo >= 2048) lo -= 4096;
                   e0 = ((imm - 32'(lo)) & 32'hfffff000) | (32'(v.rd) << 7) | 32'h37;
                   if (lo != 0) begin
                       n = 2;
                       e1 = itype(32'h13, 0, v.rd, v.rd, 32'(lo));
                   end
               end
            default: n = 0;
        endcase
    endfunction

    task automatic send(input vec_t v, input bit bp);
        int cyc, ng, err_cyc;
        logic [31:0] got[2], hold_i;
        logic gl[2], hold_l;
        bit holding, done;
        cyc = 0; ng = 0; err_cyc = 0; holding = 0; done = 0;
        while (!req_ready && cyc < 20) begin tick; cyc++; end
        chk("ready_wait", {31'd0, req_ready}, 1);
        {req_kind, req_funct3, req_funct7, req_rd, req_rs1, req_rs2, req_imm} =
            {v.kind, v.f3, v.f7, v.rd, v.rs1, v.rs2, v.imm};
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        {req_kind, req_funct3, req_funct7, req_rd, req_rs1, req_rs2} = 29'($urandom);
        req_imm = $urandom;
        chk("first_resp", {30'd0, err, out_valid}, v.n == 0 ? 2 : 1);
        cyc = 0;
        while (v.n == 0 ? cyc < 3 : (!done && cyc < 12)) begin
            out_ready = (bp && v.n != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (holding) begin
                chk("hold_valid", {31'd0, out_valid}, 1);
                chk("hold_instr", out_instr, hold_i);
                chk("hold_last", {31'd0, out_last}, {31'd0, hold_l});
            end
            if (err) err_cyc++;
            if (out_valid) begin
                chk("busy_ready", {31'd0, req_ready}, 0);
                if (out_ready) begin
                    if (ng < 2) begin got[ng] = out_instr; gl[ng] = out_last; end
                    ng++;
                    holding = 0;
                    done = out_last;
                end else begin
                    holding = 1;
                    hold_i = out_instr;
                    hold_l = out_last;
                end
            end
            tick;
            cyc++;
        end
        chk("err_cycles", err_cyc, v.n == 0 ? 1 : 0);
        chk("num_words", ng, v.n);
        if (v.n >= 1 && ng >= 1) begin
            chk("word0", got[0], v.w0);
            chk("last0", {31'd0, gl[0]}, v.n == 1 ? 1 : 0);
        end
        if (v.n == 2 && ng >= 2) begin
            chk("word1", got[1], v.w1);
            chk("last1", {31'd0, gl[1]}, 1);
        end
        exp_count += v.n;
        chk("instr_count", {16'd0, instr_count}, exp_count & 32'hffff);
    endtask

    initial begin
        vec_t v;
        tbl[0]  = '{4'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'h0, 1, 32'h002081B3, 32'h0};
        tbl[1]  = '{4'd9, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345678, 2, 32'h123452B7, 32'h67828293};
        tbl[2]  = '{4'd9, 3'd0, 7'd0, 5'd6, 5'd0, 5'd0, 32'h00001800, 2, 32'h00002337, 32'h80030313};
        tbl[3]  = '{4'd9, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1, 32'hFFF00093, 32'h0};
        tbl[4]  = '{4'd9, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'h00010000, 1, 32'h000103B7, 32'h0};
        tbl[5]  = '{4'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd5, 0, 32'h0, 32'h0};
        tbl[6]  = '{4'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd5000, 0, 32'h0, 32'h0};
        tbl[7]  = '{4'd3, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd2048, 0, 32'h0, 32'h0};
        tbl[8]  = '{4'd12, 3'd0, 7'd0, 5'd1, 5'd1, 5'd2, 32'd0, 0, 32'h0, 32'h0};
        tbl[9]  = '{4'd5, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 1, 32'h008000EF, 32'h0};
        tbl[10] = '{4'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1, 32'h00208463, 32'h0};
        tbl[11] = '{4'd3, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd4, 1, 32'h0020A223, 32'h0};
        tbl[12] = '{4'd1, 3'd5, 7'h20, 5'd1, 5'd2, 5'd0, 32'd3, 1, 32'h40315093, 32'h0};
        tbl[13] = '{4'd1, 3'd1, 7'h00, 5'd1, 5'd2, 5'd0, 32'd32, 0, 32'h0, 32'h0};
        tbl[14] = '{4'd7, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h12345FFF, 1, 32'h123450B7, 32'h0};
        tbl[15] = '{4'd6, 3'd7, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 1, 32'hFFC100E7, 32'h0};

        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_req_ready", {31'd0, req_ready}, 1);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_out_last", {31'd0, out_last}, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_count", {16'd0, instr_count}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        foreach (tbl[i]) send(tbl[i], 1'b0);

        // backpressure on the first word of a two-word LI
        {req_kind, req_rd, req_imm} = {4'd9, 5'd5, 32'h12345678};
        req_valid = 1'b1;
        out_ready = 1'b0;
        tick;
        req_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("bp_word1", out_instr, 32'h123452B7);
            chk("bp_last", {31'd0, out_last}, 0);
            chk("bp_ready", {31'd0, req_ready}, 0);
            chk("bp_valid", {31'd0, out_valid}, 1);
            tick;
        end
        out_ready = 1'b1;
        chk("bp_rel_word1", out_instr, 32'h123452B7);
        tick;
        chk("bp_word2", out_instr, 32'h67828293);
        chk("bp_last2", {31'd0, out_last}, 1);
        chk("bp_valid2", {31'd0, out_valid}, 1);
        tick;
        chk("bp_done", {31'd0, out_valid}, 0);
        exp_count += 2;
        chk("bp_count", {16'd0, instr_count}, exp_count & 32'hffff);

        // reset while the second LI word is being presented
        {req_kind, req_rd, req_imm} = {4'd9, 5'd6, 32'h00001800};
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        tick;
        out_ready = 1'b0;
        chk("pre_rst_word2", out_instr, 32'h80030313);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 0);
        chk("mid_rst_count", {16'd0, instr_count}, 0);
        chk("mid_rst_ready", {31'd0, req_ready}, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        exp_count = 0;
        send(tbl[0], 1'b0);

        for (int i = 0; i < 300; i++) begin
            v.kind = 4'($urandom_range(0, 15));
            v.f3 = 3'($urandom);
            v.f7 = 7'($urandom);
            v.rd = 5'($urandom);
            v.rs1 = 5'($urandom);
            v.rs2 = 5'($urandom);
            case ($urandom_range(0, 3))
                0: v.imm = $urandom;
                1: v.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                2: v.imm = 32'($urandom_range(0, 63));
                default: v.imm = 32'($urandom_range(0, 32'h3FFFFF)) - 32'h200000;
            endcase
            model(v, v.n, v.w0, v.w1);
            send(v, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
